// File: rtl/onchip_memory_dp.sv
// onchip_memory_dp
// Dual-port on-chip RAM with two independent, always-ready access ports that share one clock
// and one global clock enable.
//
// Parameters
//   DATA_WIDTH   : word width in bits. It must be a multiple of 8.
//   ADDR_WIDTH   : word address width. The memory holds 2**ADDR_WIDTH words.
//   READ_LATENCY : number of enabled cycles from an accepted read to readdatavalid (1 or 2).
//
// Ports
//   clk, reset     : rising-edge clock; asynchronous, active-high reset.
//   clken          : global enable. While it is low, nothing is written and the read
//                    pipelines hold their state.
//   sN_address     : word address for port N.
//   sN_byteenable  : byte lane enables for writes on port N.
//   sN_chipselect  : access qualifier for port N.
//   sN_read        : read qualifier for port N.
//   sN_write       : write qualifier for port N.
//   sN_writedata   : write data for port N.
//   sN_readdata    : read data for port N. It is valid only while sN_readdatavalid is high.
//   sN_readdatavalid : one-cycle strobe that marks valid read data.
//   collision_count  : saturating count of cycles in which both ports write the same address.
//
// Configuration macro
//   ONCHIP_MEMORY_DP_COLLISION_CNT_EN : when defined, the collision counter is built.
//                                       When undefined, collision_count is tied to 0.
module onchip_memory_dp #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 10,
  parameter int READ_LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clken,
  input  logic [ADDR_WIDTH-1:0]   s1_address,
  input  logic [DATA_WIDTH/8-1:0] s1_byteenable,
  input  logic                    s1_chipselect,
  input  logic                    s1_read,
  input  logic                    s1_write,
  input  logic [DATA_WIDTH-1:0]   s1_writedata,
  output logic [DATA_WIDTH-1:0]   s1_readdata,
  output logic                    s1_readdatavalid,
  input  logic [ADDR_WIDTH-1:0]   s2_address,
  input  logic [DATA_WIDTH/8-1:0] s2_byteenable,
  input  logic                    s2_chipselect,
  input  logic                    s2_read,
  input  logic                    s2_write,
  input  logic [DATA_WIDTH-1:0]   s2_writedata,
  output logic [DATA_WIDTH-1:0]   s2_readdata,
  output logic                    s2_readdatavalid,
  output logic [15:0]             collision_count
);

  localparam int DEPTH  = 1 << ADDR_WIDTH;
  localparam int NBYTES = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic wr1, wr2, rd1, rd2, same_addr;

  // An access is accepted only while enabled and out of reset.
  // Accesses presented during reset are therefore ignored.
  assign wr1       = clken && !reset && s1_chipselect && s1_write;
  assign wr2       = clken && !reset && s2_chipselect && s2_write;
  assign rd1       = clken && !reset && s1_chipselect && s1_read;
  assign rd2       = clken && !reset && s2_chipselect && s2_read;
  assign same_addr = (s1_address == s2_address);

  // Byte-lane writes. The memory is deliberately not reset.
  // When both ports write the same address, port 1 owns every lane it enables.
  // Port 2 only lands in the lanes that port 1 leaves alone.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NBYTES; i++) begin
      if (wr2 && s2_byteenable[i] && !(wr1 && same_addr && s1_byteenable[i]))
        mem[s2_address][i*8 +: 8] <= s2_writedata[i*8 +: 8];
      if (wr1 && s1_byteenable[i])
        mem[s1_address][i*8 +: 8] <= s1_writedata[i*8 +: 8];
    end
  end

  // Per-port read pipelines of {valid, data}.
  // Stage 0 samples the array before this edge's write lands, which gives
  // read-before-write behaviour both within a port and across the two ports.
  logic [READ_LATENCY-1:0] v1, v2;
  logic [DATA_WIDTH-1:0]   d1 [READ_LATENCY];
  logic [DATA_WIDTH-1:0]   d2 [READ_LATENCY];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v1 <= '0;
      v2 <= '0;
      for (int k = 0; k < READ_LATENCY; k++) begin
        d1[k] <= '0;
        d2[k] <= '0;
      end
    end else if (clken) begin
      v1[0] <= rd1;
      v2[0] <= rd2;
      d1[0] <= mem[s1_address];
      d2[0] <= mem[s2_address];
      for (int k = 1; k < READ_LATENCY; k++) begin
        v1[k] <= v1[k-1];
        v2[k] <= v2[k-1];
        d1[k] <= d1[k-1];
        d2[k] <= d2[k-1];
      end
    end
  end

  assign s1_readdatavalid = v1[READ_LATENCY-1];
  assign s2_readdatavalid = v2[READ_LATENCY-1];
  assign s1_readdata      = d1[READ_LATENCY-1];
  assign s2_readdata      = d2[READ_LATENCY-1];

`ifdef ONCHIP_MEMORY_DP_COLLISION_CNT_EN
  logic [15:0] coll_cnt;

  // Counts each cycle in which both ports write the same address.
  // The count sticks at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      coll_cnt <= '0;
    else if (wr1 && wr2 && same_addr && coll_cnt != 16'hFFFF)
      coll_cnt <= coll_cnt + 16'd1;
  end

  assign collision_count = coll_cnt;
`else
  assign collision_count = '0;
`endif

endmodule

// File: tb/tb_onchip_memory_dp.sv
// tb_onchip_memory_dp
// Self-checking bench for onchip_memory_dp.
//
// Two instances share every input. dut_a uses READ_LATENCY=1 and dut_b uses READ_LATENCY=2.
//
// The reference model records, for every enabled edge, which reads were accepted and what the
// memory held at that moment. The expected output after enabled edge e is then the record from
// edge e-LAT+1, provided that edge came after the most recent reset.
//
// If the bench is compiled with ONCHIP_MEMORY_DP_COLLISION_CNT_EN defined, it also expects a
// live collision counter.
module tb_onchip_memory_dp;

  localparam int DW   = 32;
  localparam int AW   = 10;
  localparam int NB   = DW / 8;
  localparam int MAXE = 8192;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic clken = 1'b0;
  logic [AW-1:0] s1_address = '0, s2_address = '0;
  logic [NB-1:0] s1_byteenable = '0, s2_byteenable = '0;
  logic s1_chipselect = 1'b0, s1_read = 1'b0, s1_write = 1'b0;
  logic s2_chipselect = 1'b0, s2_read = 1'b0, s2_write = 1'b0;
  logic [DW-1:0] s1_writedata = '0, s2_writedata = '0;

  logic [DW-1:0] a_s1_readdata, a_s2_readdata, b_s1_readdata, b_s2_readdata;
  logic a_s1_readdatavalid, a_s2_readdatavalid, b_s1_readdatavalid, b_s2_readdatavalid;
  logic [15:0] a_collision_count, b_collision_count;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  logic [DW-1:0] mdl [1 << AW];
  bit            acc_h [2][MAXE];
  logic [DW-1:0] dat_h [2][MAXE];
  int            e = 0;
  int            start_idx = 0;
  int            cc_model = 0;

  always #5 clk = ~clk;

  onchip_memory_dp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(1)) dut_a (
    .clk(clk), .reset(reset), .clken(clken),
    .s1_address(s1_address), .s1_byteenable(s1_byteenable), .s1_chipselect(s1_chipselect),
    .s1_read(s1_read), .s1_write(s1_write), .s1_writedata(s1_writedata),
    .s1_readdata(a_s1_readdata), .s1_readdatavalid(a_s1_readdatavalid),
    .s2_address(s2_address), .s2_byteenable(s2_byteenable), .s2_chipselect(s2_chipselect),
    .s2_read(s2_read), .s2_write(s2_write), .s2_writedata(s2_writedata),
    .s2_readdata(a_s2_readdata), .s2_readdatavalid(a_s2_readdatavalid),
    .collision_count(a_collision_count)
  );

  onchip_memory_dp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(2)) dut_b (
    .clk(clk), .reset(reset), .clken(clken),
    .s1_address(s1_address), .s1_byteenable(s1_byteenable), .s1_chipselect(s1_chipselect),
    .s1_read(s1_read), .s1_write(s1_write), .s1_writedata(s1_writedata),
    .s1_readdata(b_s1_readdata), .s1_readdatavalid(b_s1_readdatavalid),
    .s2_address(s2_address), .s2_byteenable(s2_byteenable), .s2_chipselect(s2_chipselect),
    .s2_read(s2_read), .s2_write(s2_write), .s2_writedata(s2_writedata),
    .s2_readdata(b_s2_readdata), .s2_readdatavalid(b_s2_readdatavalid),
    .collision_count(b_collision_count)
  );

  // Counts one comparison and reports it on a mismatch.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int expCollision();
`ifdef ONCHIP_MEMORY_DP_COLLISION_CNT_EN
    return cc_model;
`else
    return 0;
`endif
  endfunction

  // Checks one port of one instance against the recorded history.
  task automatic comparePort(input string name, input int lat, input int p,
                             input logic v, input logic [DW-1:0] d);
    int  k;
    bit  ev;
    if (e == start_idx) begin
      checkOutput({name, "_valid"}, 32'(v), 32'd0);
      checkOutput({name, "_data"}, d, 32'd0);
    end else begin
      k  = e - lat;
      ev = (k >= start_idx) && acc_h[p][k];
      checkOutput({name, "_valid"}, 32'(v), 32'(ev));
      if (ev) checkOutput({name, "_data"}, d, dat_h[p][k]);
    end
  endtask

  // Reset discards everything in flight. Only history recorded after reset counts.
  always @(posedge reset) begin
    start_idx = e;
    cc_model  = 0;
  end

  // Model update at each enabled edge, then a comparison of all outputs just after the edge.
  always @(posedge clk) begin
    if (!reset && clken) begin
      if (e >= MAXE - 1) begin
        $display("[TB] FAIL history_budget: got %0d expected below %0d", e, MAXE - 1);
        $fatal(1, "[TB] history budget exhausted");
      end
      acc_h[0][e] = s1_chipselect && s1_read;
      acc_h[1][e] = s2_chipselect && s2_read;
      dat_h[0][e] = mdl[s1_address];
      dat_h[1][e] = mdl[s2_address];
      if (s1_chipselect && s1_write && s2_chipselect && s2_write &&
          s1_address == s2_address && cc_model != 65535)
        cc_model++;
      // Port 2 writes first and port 1 writes second, so port 1 wins any lane both enable.
      for (int i = 0; i < NB; i++) begin
        if (s2_chipselect && s2_write && s2_byteenable[i])
          mdl[s2_address][i*8 +: 8] = s2_writedata[i*8 +: 8];
      end
      for (int i = 0; i < NB; i++) begin
        if (s1_chipselect && s1_write && s1_byteenable[i])
          mdl[s1_address][i*8 +: 8] = s1_writedata[i*8 +: 8];
      end
      e++;
    end
    #1;
    comparePort("a_s1", 1, 0, a_s1_readdatavalid, a_s1_readdata);
    comparePort("a_s2", 1, 1, a_s2_readdatavalid, a_s2_readdata);
    comparePort("b_s1", 2, 0, b_s1_readdatavalid, b_s1_readdata);
    comparePort("b_s2", 2, 1, b_s2_readdatavalid, b_s2_readdata);
    checkOutput("a_collision", 32'(a_collision_count), 32'(expCollision()));
    checkOutput("b_collision", 32'(b_collision_count), 32'(expCollision()));
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    s1_chipselect = 0; s1_read = 0; s1_write = 0;
    s2_chipselect = 0; s2_read = 0; s2_write = 0;
  endtask

  task automatic applyStimulus(input int port, input bit rd, input bit wr, input logic [AW-1:0] addr,
                               input logic [DW-1:0] data, input logic [NB-1:0] be);
    if (port == 1) begin
      s1_chipselect = 1; s1_read = rd; s1_write = wr;
      s1_address = addr; s1_writedata = data; s1_byteenable = be;
    end else begin
      s2_chipselect = 1; s2_read = rd; s2_write = wr;
      s2_address = addr; s2_writedata = data; s2_byteenable = be;
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_a_s1v"}, 32'(a_s1_readdatavalid), 32'd0);
    checkOutput({tag, "_b_s2v"}, 32'(b_s2_readdatavalid), 32'd0);
    checkOutput({tag, "_b_s2d"}, b_s2_readdata, 32'd0);
    checkOutput({tag, "_a_cc"}, 32'(a_collision_count), 32'd0);
  endtask

  initial begin
    #1 reset = 1;
    #1 checkAllZero("reset_init");
    step(); step();
    reset = 0;
    clken = 1;

    // Fill every address with a random word, then read every address back through both ports.
    for (int a = 0; a < (1 << AW); a++) begin
      idle(); applyStimulus(1, 0, 1, AW'(a), $urandom, 4'hF); step();
    end
    for (int a = 0; a < (1 << AW); a += 2) begin
      idle();
      applyStimulus(1, 1, 0, AW'(a), '0, '0);
      applyStimulus(2, 1, 0, AW'(a + 1), '0, '0);
      step();
    end

    // Write followed by read with single-cycle latency.
    idle(); applyStimulus(1, 0, 1, 10'd5, 32'hDEADBEEF, 4'hF); step();
    idle(); applyStimulus(1, 1, 0, 10'd5, '0, '0); step();
    checkOutput("lat1_valid", 32'(a_s1_readdatavalid), 32'd1);
    checkOutput("lat1_data", a_s1_readdata, 32'hDEADBEEF);

    // Partial byte-enable write.
    idle(); applyStimulus(1, 0, 1, 10'd7, 32'h11223344, 4'hF); step();
    idle(); applyStimulus(2, 0, 1, 10'd7, 32'hAABBCCDD, 4'b0101); step();
    idle(); applyStimulus(2, 1, 0, 10'd7, '0, '0); step();
    checkOutput("byteen_data", a_s2_readdata, 32'h11BB33DD);

    // Same-address dual write.
    idle();
    applyStimulus(1, 0, 1, 10'd3, 32'h000000FF, 4'b0001);
    applyStimulus(2, 0, 1, 10'd3, 32'hFFFFFF00, 4'b1111);
    step();
`ifdef ONCHIP_MEMORY_DP_COLLISION_CNT_EN
    checkOutput("collision_one", 32'(a_collision_count), 32'd1);
`else
    checkOutput("collision_off", 32'(a_collision_count), 32'd0);
`endif
    idle(); applyStimulus(1, 1, 0, 10'd3, '0, '0); step();
    checkOutput("collision_data", a_s1_readdata, 32'hFFFFFFFF);

    // Read-before-write, both on the same port and across ports.
    idle(); applyStimulus(1, 0, 1, 10'd1, 32'h1, 4'hF); step();
    idle();
    applyStimulus(1, 1, 1, 10'd1, 32'h2, 4'hF);
    applyStimulus(2, 1, 0, 10'd1, '0, '0);
    step();
    checkOutput("rbw_s1_old", a_s1_readdata, 32'h1);
    checkOutput("rbw_s2_old", a_s2_readdata, 32'h1);
    idle(); applyStimulus(1, 1, 0, 10'd1, '0, '0); step();
    checkOutput("rbw_new", a_s1_readdata, 32'h2);

    // clken stall on the two-cycle instance.
    idle(); applyStimulus(1, 0, 1, 10'd9, 32'h09090909, 4'hF); step();
    idle(); applyStimulus(2, 1, 0, 10'd9, '0, '0); step();
    idle(); clken = 0; step();
    checkOutput("stall_held_invalid", 32'(b_s2_readdatavalid), 32'd0);
    clken = 1; step();
    checkOutput("stall_valid", 32'(b_s2_readdatavalid), 32'd1);
    checkOutput("stall_data", b_s2_readdata, 32'h09090909);

    // Reset while a read is in flight. A write presented during reset must be ignored.
    idle(); applyStimulus(2, 1, 0, 10'd9, '0, '0); step();
    idle(); applyStimulus(1, 0, 1, 10'd9, 32'h0BAD0BAD, 4'hF);
    reset = 1;
    #1 checkAllZero("reset_flight");
    step(); step();
    idle(); reset = 0;
    step();
    checkOutput("flush_b_s2v_0", 32'(b_s2_readdatavalid), 32'd0);
    step();
    checkOutput("flush_b_s2v_1", 32'(b_s2_readdatavalid), 32'd0);
    idle(); applyStimulus(1, 1, 0, 10'd9, '0, '0); step();
    checkOutput("mem_kept", a_s1_readdata, 32'h09090909);

    // Randomized traffic with occasional stalls, collisions and resets.
    for (int n = 0; n < 3000; n++) begin
      idle();
      clken = ($urandom_range(0, 9) != 0);
      for (int p = 1; p <= 2; p++) begin
        if ($urandom_range(0, 3) != 0)
          applyStimulus(p, 1'($urandom), 1'($urandom),
                        ($urandom_range(0, 7) == 0) ? AW'($urandom) : AW'($urandom_range(0, 15)),
                        $urandom, NB'($urandom));
      end
      if ($urandom_range(0, 3) == 0) s2_address = s1_address;
      if ($urandom_range(0, 399) == 0) begin
        reset = 1;
        #1 checkAllZero("reset_rand");
        step();
        reset = 0;
      end else begin
        step();
      end
    end

    idle(); clken = 1;
    step(); step(); step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
